// File: rtl/mux_n_pipe.sv
// N-channel valid/ready multiplexer feeding a single-entry registered output buffer.
// Define MUX_RR_EN to replace the manual select register with round-robin arbitration.
module mux_n_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_err,
    output logic [WIDTH-1:0]          dout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          xfer_cnt
);

    logic             space_c;
    logic             accept_c;
    logic [WIDTH-1:0] data_c;
    logic [SEL_W-1:0] grant_c;

    assign space_c = !out_valid || out_ready;
    assign cur_sel = grant_c;

    // Steer ready/data for the granted channel only
    always_comb begin
        in_ready = '0;
        accept_c = 1'b0;
        data_c   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == grant_c) begin
                in_ready[i] = space_c;
                accept_c    = in_valid[i] && space_c;
                data_c      = din[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] ptr;
    int unsigned      rr_dist_c;
    int unsigned      rr_best_c;
    logic             unused_c;

    assign unused_c = ^{sel, sel_load};
    assign sel_err  = 1'b0;

    // Grant the valid channel closest to ptr going upward, wrapping at CHANNELS
    always_comb begin
        grant_c   = ptr;
        rr_best_c = CHANNELS;
        rr_dist_c = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            rr_dist_c = (i >= 32'(ptr)) ? i - 32'(ptr) : i + CHANNELS - 32'(ptr);
            if (in_valid[i] && (rr_dist_c < rr_best_c)) begin
                rr_best_c = rr_dist_c;
                grant_c   = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept_c) begin
            ptr <= (32'(grant_c) == CHANNELS - 1) ? '0 : grant_c + SEL_W'(1);
        end
    end
`else
    localparam int unsigned SEL_N = 1 << SEL_W;

    logic [SEL_W-1:0] sel_q;
    logic [SEL_N-1:0] sel_ok_c;

    assign grant_c = sel_q;

    always_comb begin
        sel_ok_c = '0;
        for (int unsigned i = 0; i < SEL_N; i++) begin
            sel_ok_c[i] = (i < CHANNELS);
        end
    end

    // Out-of-range loads keep the old channel and latch the error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            sel_err <= 1'b0;
        end else if (sel_load) begin
            if (sel_ok_c[sel]) begin
                sel_q <= sel;
            end else begin
                sel_err <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            out_valid <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            if (accept_c) begin
                dout     <= data_c;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            out_valid <= accept_c || (out_valid && !out_ready);
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe: directed scenarios plus randomized traffic against a
// transaction-level model. Builds for either select mode (MUX_RR_EN defined or not).
module tb_mux_n_pipe;

    localparam int unsigned W   = 8;
    localparam int unsigned CH  = 4;
    localparam int unsigned SW  = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned CH3 = 3;
    localparam int unsigned CW3 = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*W-1:0] din;
    logic [CH-1:0]   in_valid, in_ready;
    logic [SW-1:0]   sel, cur_sel;
    logic            sel_load, sel_err, out_valid, out_ready;
    logic [W-1:0]    dout;
    logic [CW-1:0]   xfer_cnt;

    logic [CH3*W-1:0] d3_din;
    logic [CH3-1:0]   d3_in_valid, d3_in_ready;
    logic [SW-1:0]    d3_sel, d3_cur_sel;
    logic             d3_sel_load, d3_sel_err, d3_out_valid, d3_out_ready;
    logic [W-1:0]     d3_dout;
    logic [CW3-1:0]   d3_xfer_cnt;

    always #5 clk = ~clk;

    mux_n_pipe #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .sel_load(sel_load), .cur_sel(cur_sel), .sel_err(sel_err),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    mux_n_pipe #(.WIDTH(W), .CHANNELS(CH3), .SEL_W(SW), .CNT_W(CW3)) dut3 (
        .clk(clk), .rst_n(rst_n), .din(d3_din), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .sel(d3_sel), .sel_load(d3_sel_load), .cur_sel(d3_cur_sel), .sel_err(d3_sel_err),
        .dout(d3_dout), .out_valid(d3_out_valid), .out_ready(d3_out_ready), .xfer_cnt(d3_xfer_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the output buffer as a queue of accepted words
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_last;
    int unsigned  m_cnt, m_sel, m_ptr;
    logic         m_err;
    int unsigned  obs_sel;
    logic [W-1:0] t2v[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_last = '0;
        m_cnt  = 0;
        m_sel  = 0;
        m_ptr  = 0;
        m_err  = 1'b0;
    endtask

    function automatic int unsigned m_grant();
`ifdef MUX_RR_EN
        for (int unsigned k = 0; k < CH; k++) begin
            if (in_valid[SW'((m_ptr + k) % CH)]) return (m_ptr + k) % CH;
        end
        return m_ptr;
`else
        return m_sel;
`endif
    endfunction

    // One clock: check combinational outputs, advance the model at the edge, check registers
    task automatic cycle();
        int unsigned   g;
        logic          space, acc;
        logic [CH-1:0] exp_rdy;
        #1;
        g       = m_grant();
        space   = (exp_q.size() == 0) || out_ready;
        acc     = in_valid[SW'(g)] && space;
        exp_rdy = '0;
        if (space) exp_rdy[SW'(g)] = 1'b1;
        obs_sel = 32'(cur_sel);
        chk("cur_sel", 32'(cur_sel), g);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid_pre", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("dout_pre", 32'(dout), 32'(m_last));
        @(posedge clk);
        if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
        if (acc) begin
            m_last = din[g*W +: W];
            exp_q.push_back(m_last);
            m_cnt = (m_cnt + 1) % (32'd1 << CW);
        end
`ifdef MUX_RR_EN
        if (acc) m_ptr = (g + 1) % CH;
`else
        if (sel_load) begin
            if (32'(sel) < CH) m_sel = 32'(sel);
            else m_err = 1'b1;
        end
`endif
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("dout", 32'(dout), 32'(m_last));
        chk("xfer_cnt", 32'(xfer_cnt), m_cnt);
        chk("sel_err", 32'(sel_err), 32'(m_err));
    endtask

    initial begin
        rst_n = 1'b0; din = '0; in_valid = '0; sel = '0; sel_load = 1'b0; out_ready = 1'b0;
        d3_din = '0; d3_in_valid = '0; d3_sel = '0; d3_sel_load = 1'b0; d3_out_ready = 1'b0;
        t2v[0] = 8'h11; t2v[1] = 8'h22; t2v[2] = 8'h33;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
        chk("rst_cur_sel", 32'(cur_sel), 0);
        chk("rst_sel_err", 32'(sel_err), 0);
        rst_n = 1'b1;

        // Asynchronous reset while a word is buffered
        in_valid = 4'b0001; din[7:0] = 8'h77;
        cycle();
        chk("t1_buffered", 32'(out_valid), 1);
        in_valid = '0;
        #2; rst_n = 1'b0; #1;
        m_reset();
        chk("t1_out_valid", 32'(out_valid), 0);
        chk("t1_dout", 32'(dout), 0);
        chk("t1_xfer_cnt", 32'(xfer_cnt), 0);
        chk("t1_cur_sel", 32'(cur_sel), 0);
        in_valid = 4'b1111;
        @(posedge clk); #1;
        chk("t1_hold_valid", 32'(out_valid), 0);
        chk("t1_hold_cnt", 32'(xfer_cnt), 0);
        in_valid = '0;
        rst_n = 1'b1;

`ifdef MUX_RR_EN
        // Round-robin with all channels requesting, then only channels 1 and 3
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = (CH*W)'($urandom);
            cycle();
            chk("rr_all_grant", obs_sel, 32'(i % 4));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            din = (CH*W)'($urandom);
            cycle();
            chk("rr_pair_grant", obs_sel, (i % 2 == 1) ? 3 : 1);
        end
        in_valid = '0;
        d3_sel = 2'd3; d3_sel_load = 1'b1;
        cycle();
        chk("rr_sel_err_zero", 32'(d3_sel_err), 0);
        d3_sel_load = 1'b0;
`else
        // Manual streaming from channel 2
        out_ready = 1'b1; sel = 2'd2; sel_load = 1'b1;
        cycle();
        sel_load = 1'b0;
        chk("t2_cur_sel", 32'(cur_sel), 2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b0100; din[23:16] = t2v[i];
            cycle();
            chk("t2_dout", 32'(dout), 32'(t2v[i]));
            chk("t2_out_valid", 32'(out_valid), 1);
            chk("t2_rdy_other", 32'(in_ready & 4'b1011), 0);
        end
        in_valid = '0;
        cycle();
        chk("t2_xfer_cnt", 32'(xfer_cnt), 3);

        // Backpressure holds the buffered word, release drains and accepts at one edge
        in_valid = 4'b0100; din[23:16] = 8'hA5;
        cycle();
        din[23:16] = 8'hB6; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_dout_held", 32'(dout), 'hA5);
            chk("t3_rdy_low", 32'(in_ready[2]), 0);
        end
        out_ready = 1'b1;
        cycle();
        chk("t3_next_word", 32'(dout), 'hB6);
        chk("t3_still_valid", 32'(out_valid), 1);
        in_valid = '0;
        cycle();
        chk("t3_drained", 32'(out_valid), 0);
        chk("t3_xfer_cnt", 32'(xfer_cnt), 5);

        // Select change at the same edge as an accept
        sel = 2'd0; sel_load = 1'b1;
        cycle();
        in_valid = 4'b0001; din[7:0] = 8'h5A; sel = 2'd1;
        cycle();
        sel_load = 1'b0; in_valid = '0;
        chk("t4_dout", 32'(dout), 'h5A);
        chk("t4_cur_sel", 32'(cur_sel), 1);
        cycle();

        // Three-channel instance: illegal select and 4-bit counter wrap
        d3_sel = 2'd2; d3_sel_load = 1'b1;
        cycle();
        chk("t5_cur_sel_load", 32'(d3_cur_sel), 2);
        chk("t5_err_clear", 32'(d3_sel_err), 0);
        d3_sel = 2'd3;
        cycle();
        d3_sel_load = 1'b0;
        chk("t5_cur_sel_hold", 32'(d3_cur_sel), 2);
        chk("t5_sel_err", 32'(d3_sel_err), 1);
        chk("t5_cnt_start", 32'(d3_xfer_cnt), 0);
        d3_in_valid = 3'b100; d3_out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            d3_din[23:16] = 8'(i);
            cycle();
        end
        d3_in_valid = '0;
        cycle();
        chk("t5_cnt_wrap", 32'(d3_xfer_cnt), 1);
        chk("t5_last_word", 32'(d3_dout), 16);
        chk("t5_err_sticky", 32'(d3_sel_err), 1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = CH'($urandom);
            din       = (CH*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom);
            sel_load  = ($urandom_range(0, 7) == 0);
            cycle();
        end
        in_valid = '0; sel_load = 1'b0; out_ready = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
